mmio_uart_queue: RTL

Parametrised successor to the core-side UART MMIO path: byte-assembled receive FIFO, word-serialising transmit FIFO, and status/error registers, all in one synchronous block between the core's load/store port and the UartRx/UartTx pair. Unlike the previous hub it takes a raw byte stream, uses every FIFO slot, and has a selectable overflow policy. It also provides sticky error flags and a saturating drop counter. Boot-time instruction DMA stays outside this block.

---
 rtl/mmio_uart_queue.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_queue.sv
// Core-side UART MMIO block: byte-assembling RX FIFO, word-serialising TX FIFO,
// sticky error flags and a saturating RX drop counter behind a load/store port.
module mmio_uart_queue #(
    parameter int RX_DEPTH     = 256,
    parameter int TX_DEPTH     = 64,
    parameter int WORD_BYTES   = 4,
    parameter bit RX_OVERWRITE = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        write_enable,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        tx_start,
    output logic [7:0]  sdata,
    input  logic        tx_busy
);
    localparam int WW  = 8 * WORD_BYTES;
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int BCW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [RAW:0]   RX_FULL   = (RAW+1)'(RX_DEPTH);
    localparam logic [RAW:0]   RX_ONE    = (RAW+1)'(1);
    localparam logic [TAW:0]   TX_FULL   = (TAW+1)'(TX_DEPTH);
    localparam logic [TAW:0]   TX_ONE    = (TAW+1)'(1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(WORD_BYTES - 1);
    localparam logic [BCW-1:0] BC_ONE    = BCW'(1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} tx_state_e;

    logic sel_status, sel_rxdata, sel_rxcount, sel_txdata, sel_txfree;
    assign sel_status  = address[31] && (address[3:0] == 4'h0);
    assign sel_rxdata  = address[31] && (address[3:0] == 4'h1);
    assign sel_rxcount = address[31] && (address[3:0] == 4'h2);
    assign sel_txdata  = address[31] && (address[3:0] == 4'h4);
    assign sel_txfree  = address[31] && (address[3:0] == 4'h8);

    logic unused_bits;
    assign unused_bits = ^{address[30:4], write_data};

    logic [WW-1:0]  rx_mem [RX_DEPTH];
    logic [RAW:0]   rx_wr_q, rx_rd_q, rx_count;
    logic [BCW-1:0] bcnt_q;
    logic [WW-1:0]  asm_q, asm_d;
    logic           rx_full, rx_empty, rx_push, rx_pop, rx_drop, rx_wr_en;
    logic           rx_ovf_q, tx_drop_q;
    logic [15:0]    drop_cnt_q;

    assign rx_count = rx_wr_q - rx_rd_q;
    assign rx_full  = (rx_count == RX_FULL);
    assign rx_empty = (rx_count == '0);
    assign rx_pop   = sel_rxdata && !write_enable && !rx_empty;
    assign rx_push  = rx_valid && (bcnt_q == LAST_BYTE);
    assign rx_drop  = rx_push && rx_full && !rx_pop;
    // When full without a pop, overwrite mode still writes: the tail slot is the head slot.
    assign rx_wr_en = rx_push && (!rx_full || rx_pop || RX_OVERWRITE);

    always_comb begin
        asm_d = asm_q;
        if (rx_valid) asm_d[{bcnt_q, 3'b000} +: 8] = rx_data;
    end

    logic [WW-1:0] tx_mem [TX_DEPTH];
    logic [TAW:0]  tx_wr_q, tx_rd_q, tx_count, tx_free;
    logic          tx_full, tx_empty, tx_wr, tx_push, tx_wr_drop, tx_pop;

    assign tx_count   = tx_wr_q - tx_rd_q;
    assign tx_full    = (tx_count == TX_FULL);
    assign tx_empty   = (tx_count == '0);
    assign tx_free    = TX_FULL - tx_count;
    assign tx_wr      = sel_txdata && write_enable;
    assign tx_push    = tx_wr && !tx_full;
    assign tx_wr_drop = tx_wr && tx_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            bcnt_q     <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            rx_ovf_q   <= 1'b0;
            tx_drop_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (rx_valid) bcnt_q <= (bcnt_q == LAST_BYTE) ? '0 : bcnt_q + BC_ONE;
            if (rx_wr_en) rx_wr_q <= rx_wr_q + RX_ONE;
            if (rx_pop || (rx_drop && RX_OVERWRITE)) rx_rd_q <= rx_rd_q + RX_ONE;
            if (tx_push) tx_wr_q <= tx_wr_q + TX_ONE;
            if (tx_pop) tx_rd_q <= tx_rd_q + TX_ONE;
            if (sel_status && write_enable) begin
                rx_ovf_q   <= 1'b0;
                tx_drop_q  <= 1'b0;
                drop_cnt_q <= '0;
            end
            // A new error in the same cycle as a clearing write wins.
            if (rx_drop) begin
                rx_ovf_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (tx_wr_drop) tx_drop_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rx_valid) asm_q <= asm_d;
        if (rx_wr_en) rx_mem[rx_rd_q[RAW-1:0] ^ (rx_wr_q[RAW-1:0] ^ rx_rd_q[RAW-1:0])] <= asm_d;
        if (tx_push) tx_mem[tx_wr_q[TAW-1:0]] <= write_data[WW-1:0];
    end

    tx_state_e      state_q, state_d;
    logic [BCW-1:0] k_q, k_d;
    logic           guard_q, guard_d;
    logic [WW-1:0]  tx_word_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            guard_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            guard_q <= guard_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        guard_d = guard_q;
        case (state_q)
            IDLE: if (!tx_empty && !tx_busy) begin
                state_d = LOAD;
                k_d     = '0;
            end
            LOAD: begin
                state_d = WAIT;
                guard_d = 1'b1;
            end
            WAIT: begin
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (!tx_busy) begin
                    if (k_q == LAST_BYTE) begin
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                        k_d     = k_q + BC_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_pop   = (state_q == IDLE) && !tx_empty && !tx_busy;
        tx_start = (state_q == LOAD);
        sdata    = tx_start ? tx_word_q[{k_q, 3'b000} +: 8] : 8'h00;
    end

    always_ff @(posedge clock) begin
        if (tx_pop) tx_word_q <= tx_mem[tx_rd_q[TAW-1:0]];
    end

    always_comb begin
        read_data = '0;
        if (sel_status) begin
            read_data = {drop_cnt_q, 12'h000, tx_drop_q, rx_ovf_q, tx_full, rx_empty};
        end else if (sel_rxdata) begin
            if (!rx_empty) read_data[WW-1:0] = rx_mem[rx_rd_q[RAW-1:0]];
        end else if (sel_rxcount) begin
            read_data[RAW:0] = rx_count;
        end else if (sel_txfree) begin
            read_data[TAW:0] = tx_free;
        end
    end
endmodule
